// File: rtl/sm_clk_gen_pkg.sv
// Shared encodings and the divide-exponent helper for the sm_clk_gen clock source.
package sm_clk_gen_pkg;

  localparam logic [1:0] SM_MODE_HALT = 2'b00;
  localparam logic [1:0] SM_MODE_RUN  = 2'b01;
  localparam logic [1:0] SM_MODE_STEP = 2'b10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  // Half-period exponent, saturated so the terminal count fits the counter.
  function automatic int sm_clamp_exp(input int base, input int offs, input int max_e);
    int sum;
    sum = base + offs;
    return (sum > max_e) ? max_e : sum;
  endfunction

endpackage

// File: rtl/sm_clk_gen_sync2.sv
// sm_sync2: parametrised-width two-flop synchroniser with asynchronous active-low reset.
module sm_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // NOTE: non-blocking assignments make both flops sample together, giving a true two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sm_clk_gen.sv
// sm_clk_gen: glitch-free programmable clock with run/halt/single-step modes.
// Optional 32-bit tick counter output enabled by defining SM_CLK_GEN_CYCLE_CNT_EN.
module sm_clk_gen
  import sm_clk_gen_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SHIFT = 16,
  parameter int SEL_W = 4
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] divide,
  input  logic [1:0]       mode,
  input  logic             step,
  output logic             clkOut,
  output logic             clkTick,
  output logic             running
`ifdef SM_CLK_GEN_CYCLE_CNT_EN
  ,
  output logic [31:0]      cycleCount
`endif
);

  logic [SEL_W-1:0] w_div_s;
  logic [1:0]       w_mode_s;
  logic             w_step_s;

  sm_sync2 #(.W(SEL_W)) u_sync_div (
    .clk   (clkIn),
    .rst_n (rst_n),
    .i_d   (divide),
    .o_q   (w_div_s)
  );

  sm_sync2 #(.W(2)) u_sync_mode (
    .clk   (clkIn),
    .rst_n (rst_n),
    .i_d   (mode),
    .o_q   (w_mode_s)
  );

  sm_sync2 #(.W(1)) u_sync_step (
    .clk   (clkIn),
    .rst_n (rst_n),
    .i_d   (step),
    .o_q   (w_step_s)
  );

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_div_active;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_step_prev;
  logic             r_step_pending;

  int               w_exp;
  logic [CNT_W-1:0] w_term;
  logic             w_at_term;
  logic             w_run;
  logic             w_step_edge;

  assign w_exp       = sm_clamp_exp(SHIFT, int'(r_div_active), CNT_W - 1);
  assign w_term      = ~({CNT_W{1'b1}} << w_exp);
  assign w_at_term   = (r_cnt == w_term);
  assign w_run       = (w_mode_s == SM_MODE_RUN);
  assign w_step_edge = w_step_s & ~r_step_prev & (w_mode_s == SM_MODE_STEP);

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_div_active   <= '0;
      r_clk_out      <= 1'b0;
      r_tick         <= 1'b0;
      r_step_prev    <= 1'b0;
      r_step_pending <= 1'b0;
    end else begin
      r_step_prev <= w_step_s;
      r_tick      <= 1'b0;
      if (w_step_edge) begin
        r_step_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_run || (w_mode_s == SM_MODE_STEP && r_step_pending)) begin
            r_state      <= HIGH;
            r_div_active <= w_div_s;
            r_clk_out    <= 1'b1;
            r_tick       <= 1'b1;
          end
        end

        HIGH: begin
          if (w_at_term) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_state   <= LOW;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        LOW: begin
          if (w_at_term) begin
            r_cnt <= '0;
            if (w_run) begin
              r_state      <= HIGH;
              r_div_active <= w_div_s;
              r_clk_out    <= 1'b1;
              r_tick       <= 1'b1;
            end else begin
              // Placed after the edge set so a coincident step edge is dropped.
              r_state        <= IDLE;
              r_step_pending <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_clk_out <= 1'b0;
        end
      endcase
    end
  end

  assign clkOut  = r_clk_out;
  assign clkTick = r_tick;
  assign running = (r_state != IDLE);

`ifdef SM_CLK_GEN_CYCLE_CNT_EN
  logic [31:0] r_cycle_cnt;

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
    end else if (r_tick) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign cycleCount = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_sm_clk_gen.sv
// Scoreboard bench for sm_clk_gen: stimulus queues expected half-periods, a monitor measures clkOut.
module tb_sm_clk_gen;

  localparam int CNT_W = 8;
  localparam int SHIFT = 1;
  localparam int SEL_W = 4;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic [SEL_W-1:0] divide = '0;
  logic [1:0]       mode   = MODE_HALT;
  logic             step   = 1'b0;
  logic             clk_out;
  logic             clk_tick;
  logic             running;
`ifdef SM_CLK_GEN_CYCLE_CNT_EN
  logic [31:0]      cycle_count;
`endif

  sm_clk_gen #(
    .CNT_W (CNT_W),
    .SHIFT (SHIFT),
    .SEL_W (SEL_W)
  ) dut (
    .clkIn      (clk),
    .rst_n      (rst_n),
    .divide     (divide),
    .mode       (mode),
    .step       (step),
    .clkOut     (clk_out),
    .clkTick    (clk_tick),
    .running    (running)
`ifdef SM_CLK_GEN_CYCLE_CNT_EN
    ,
    .cycleCount (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_hi_q[$];
  int exp_lo_q[$];
  int plan[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: half-period = 2^min(SHIFT+div, CNT_W-1) source cycles.
  function automatic int half_len(input int d);
    int e;
    e = SHIFT + d;
    if (e > CNT_W - 1) e = CNT_W - 1;
    return 1 << e;
  endfunction

  function automatic int rand_div();
    if ($urandom_range(0, 4) == 4) return int'($urandom_range(6, 15));
    return int'($urandom_range(0, 3));
  endfunction

  // ---------------- monitor ----------------
  bit m_prev = 1'b0;
  bit m_in   = 1'b0;
  int m_hi, m_lo, m_err;

  task automatic close_period();
    check("period_expected", exp_hi_q.size() > 0, 1);
    if (exp_hi_q.size() > 0) begin
      check("period_high_len", m_hi, exp_hi_q.pop_front());
      check("period_low_len", m_lo, exp_lo_q.pop_front());
      check("period_tick_shape", m_err, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev = 1'b0;
      m_in   = 1'b0;
    end else begin
      if (clk_out && !m_prev) begin
        if (m_in) close_period();
        m_in  = 1'b1;
        m_hi  = 1;
        m_lo  = 0;
        m_err = (clk_tick && running) ? 0 : 1;
      end else if (clk_out) begin
        m_hi++;
        if (clk_tick || !running) m_err = 1;
      end else if (m_in) begin
        if (clk_tick) m_err = 1;
        if (running) m_lo++;
        else begin
          close_period();
          m_in = 1'b0;
        end
      end
      m_prev = clk_out;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (clk_tick) begin
        ok = 1'b1;
        break;
      end
    end
    check("tick_wait", ok, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!running) break;
    end
    check({tag, "_idle_running"}, running, 0);
    check({tag, "_idle_clkout"}, clk_out, 0);
  endtask

  // Runs the periods listed in plan, then halts during the first HIGH cycle of the last one.
  task automatic run_plan(input string tag);
    bit   ok;
    logic c1, c2, c3;
    divide = SEL_W'(plan[0]);
    repeat (4) @(negedge clk);
    mode = MODE_RUN;
    @(posedge clk); #1 c1 = clk_out;
    @(posedge clk); #1 c2 = clk_out;
    @(posedge clk); #1 c3 = clk_out;
    check({tag, "_first_rise_edge3"}, {c1, c2, c3}, 3'b001);
    @(negedge clk);
    for (int k = 0; k < plan.size(); k++) begin
      if (k > 0) begin
        wait_tick(ok);
        if (!ok) break;
      end
      exp_hi_q.push_back(half_len(plan[k]));
      exp_lo_q.push_back(half_len(plan[k]));
      if (k == plan.size() - 1) mode = MODE_HALT;
      else divide = SEL_W'(plan[k + 1]);
    end
    mode = MODE_HALT;
    wait_idle(tag);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    check("reset_clkout", clk_out, 0);
    check("reset_tick", clk_tick, 0);
    check("reset_running", running, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("halt_idle_clkout", clk_out, 0);
    check("halt_idle_running", running, 0);

`ifdef SM_CLK_GEN_CYCLE_CNT_EN
    plan = '{0, 0, 0, 0, 0};
    run_plan("cnt5");
    check("cycle_count_5", cycle_count, 5);
    force dut.r_cycle_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_cycle_cnt;
    plan = '{0};
    run_plan("cnt_wrap");
    check("cycle_count_wrap", cycle_count, 0);
`endif

    plan = '{0, 2, 2};
    run_plan("div_change");
    plan = '{15};
    run_plan("clamp");
    plan = '{0};
    run_plan("halt_first_high");

    // Single-step: three accepted pulses, clkOut parked low between them.
    divide = '0;
    mode   = MODE_STEP;
    repeat (4) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      exp_hi_q.push_back(half_len(0));
      exp_lo_q.push_back(half_len(0));
      pulse_step();
      repeat (12) @(negedge clk);
      check("step_gap_clkout", clk_out, 0);
      check("step_gap_running", running, 0);
    end

    // A step edge during an active period must not queue another period.
    divide = SEL_W'(2);
    repeat (4) @(negedge clk);
    exp_hi_q.push_back(half_len(2));
    exp_lo_q.push_back(half_len(2));
    step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clk_out) break;
    end
    check("step_active_seen", clk_out, 1);
    step = 1'b0;
    repeat (3) @(negedge clk);
    pulse_step();
    repeat (40) @(negedge clk);
    check("step_ignored_running", running, 0);
    mode = MODE_HALT;

    for (int r = 0; r < 2; r++) begin
      plan.delete();
      for (int k = 0; k < int'($urandom_range(3, 5)); k++) plan.push_back(rand_div());
      run_plan("random");
    end

    // Asynchronous reset in the middle of a HIGH half-period.
    divide = SEL_W'(2);
    repeat (4) @(negedge clk);
    mode = MODE_RUN;
    wait_tick(ok);
    repeat (2) @(negedge clk);
    #3;
    check("pre_reset_high", clk_out, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_clkout", clk_out, 0);
    check("async_reset_running", running, 0);
    mode = MODE_HALT;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_clkout", clk_out, 0);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_hi_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
